// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared opcode patterns, state encodings and opcode match helper.
package pc_sequencer_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, HALT = 2'd2} state_t;
  // Patterns span {op1, op2, op3}; only op1 is significant, op2/op3 are don't-care.
  localparam logic [12:0] OP_MASK = 13'h1fe0;
  localparam logic [12:0] Z_HLT   = {8'h01, 5'h00};
  localparam logic [12:0] Z_B     = {8'h10, 5'h00};
  localparam logic [12:0] Z_BCC   = {8'h11, 5'h00};
  localparam logic [12:0] Z_CALL  = {8'h12, 5'h00};
  localparam logic [12:0] Z_RET   = {8'h13, 5'h00};
  function automatic logic op_match(input logic [12:0] op, input logic [12:0] pat);
    return ((op ^ pat) & OP_MASK) == 13'h0;
  endfunction
endpackage

// File: rtl/pc_return_stack.sv
// pc_return_stack: circular return-address stack; overflow overwrites the oldest entry, errors are sticky.
module pc_return_stack #(
  parameter int ADDR_W   = 32,
  parameter int RS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] pop_data,
  output logic              empty,
  output logic              err
);
  localparam int PW = $clog2(RS_DEPTH);
  logic [ADDR_W-1:0] mem [RS_DEPTH];
  logic [PW-1:0] ptr;
  logic [PW:0] cnt;
  logic full;
  assign full = cnt == (PW+1)'(RS_DEPTH);
  assign empty = cnt == '0;
  assign pop_data = mem[ptr - PW'(1)];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      cnt <= '0;
      err <= 1'b0;
    end else if (push) begin
      ptr <= ptr + PW'(1);
      cnt <= full ? cnt : cnt + (PW+1)'(1);
      err <= err | full;
    end else if (pop) begin
      ptr <= empty ? ptr : ptr - PW'(1);
      cnt <= empty ? cnt : cnt - (PW+1)'(1);
      err <= err | empty;
    end
  end
  always_ff @(posedge clk) if (push) mem[ptr] <= push_data;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: RUN/STALL/HALT program counter sequencer with one-cycle registered next PC.
// Define PC_RETURN_STACK_EN to enable the CALL/RET return stack (otherwise CALL acts as B, RET as pc+1).
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int              RS_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        op1,
  input  logic [1:0]        op2,
  input  logic [2:0]        op3,
  input  logic [ADDR_W-1:0] dr,
  input  logic              cond_ok,
  input  logic              stall,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_valid,
  output logic              halted,
  output logic              rs_err
);
  if (RS_DEPTH < 2 || RS_DEPTH > 16 || (RS_DEPTH & (RS_DEPTH - 1)) != 0)
    $error("RS_DEPTH must be a power of two in 2..16");
  state_t state, state_nx;
  logic [ADDR_W-1:0] pc_nx, pc_inc, ret_pc;
  logic [12:0] op;
  logic act, is_hlt, is_b, is_bcc, is_call, is_ret;
  assign op = {op1, op2, op3};
  assign pc_inc = pc + ADDR_W'(1);
  assign act = state != HALT && !stall;
  assign is_hlt = op_match(op, Z_HLT);
  assign is_b = op_match(op, Z_B);
  assign is_bcc = op_match(op, Z_BCC);
  assign is_call = op_match(op, Z_CALL);
  assign is_ret = op_match(op, Z_RET);
`ifdef PC_RETURN_STACK_EN
  logic [ADDR_W-1:0] rs_top;
  logic rs_empty;
  pc_return_stack #(.ADDR_W(ADDR_W), .RS_DEPTH(RS_DEPTH)) u_rs (
    .clk(clk), .rst_n(rst_n), .push(act && is_call), .pop(act && is_ret),
    .push_data(pc_inc), .pop_data(rs_top), .empty(rs_empty), .err(rs_err)
  );
  assign ret_pc = rs_empty ? pc_inc : rs_top;
`else
  assign ret_pc = pc_inc;
  assign rs_err = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    pc_nx = pc;
    if (state == HALT) begin
      state_nx = resume ? RUN : HALT;
      pc_nx = resume ? pc_inc : pc;
    end else if (stall) begin
      state_nx = STALL;
    end else begin
      state_nx = is_hlt ? HALT : RUN;
      pc_nx = is_hlt ? pc :
              (is_b || is_call || (is_bcc && cond_ok)) ? dr :
              is_ret ? ret_pc : pc_inc;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      pc <= RESET_VEC;
    end else begin
      state <= state_nx;
      pc <= pc_nx;
    end
  end
  assign fetch_valid = state == RUN && !stall;
  assign halted = state == HALT;
endmodule
